mc_clz_seq: RTL



---
 rtl/mc_clz_seq_pkg.sv | 19 +
 rtl/mc_clz_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/mc_clz_seq_pkg.sv
// Shared encodings for the CLZ/CLO execute-stage sequencer.
package mc_clz_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0]  OP_CLZ         = 2'd0;
  localparam logic [1:0]  OP_CLO         = 2'd1;
  localparam logic [31:0] TIMEOUT_RESULT = 32'd32;

  function automatic logic is_legal(input logic [1:0] code);
    return (code == OP_CLZ) || (code == OP_CLO);
  endfunction

endpackage

// File: rtl/mc_clz_seq.sv
// Sequencer feeding the multi-cycle count-leading-zeros engine: latches the
// operand, launches the engine, waits for idle and reports the count.
module mc_clz_seq
  import mc_clz_seq_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_data,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        err,
  output logic        eng_start,
  output logic [31:0] eng_data,
  input  logic        eng_busy,
  input  logic [31:0] eng_result
);

  localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] watchdog;
  logic             start_reg;
  logic             legal_req;

  assign legal_req = op_valid && is_legal(op_code);
  assign stall     = (state == LAUNCH) || (state == RUN) || ((state == IDLE) && legal_req);
  // A flush landing in LAUNCH must suppress the start pulse in that same cycle.
  assign eng_start = start_reg && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      watchdog     <= '0;
      start_reg    <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err          <= 1'b0;
      eng_data     <= '0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      start_reg    <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && !flush) begin
            if (is_legal(op_code)) begin
              eng_data  <= (op_code == OP_CLO) ? ~op_data : op_data;
              start_reg <= 1'b1;
              state     <= LAUNCH;
            end else begin
              err    <= 1'b1;
              result <= '0;
            end
          end
        end
        LAUNCH: begin
          watchdog <= '0;
          state    <= flush ? IDLE : RUN;
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            watchdog <= watchdog + 1'b1;
            // Busy is only meaningful after the first RUN cycle (watchdog == 0).
            if ((watchdog != '0) && !eng_busy) begin
              result       <= eng_result;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (watchdog == LAST_RUN_CNT) begin
              result       <= TIMEOUT_RESULT;
              err          <= 1'b1;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
